// File: rtl/dlfloat_mul_pipe.sv
// dlfloat_mul_pipe: three-stage pipelined DLFloat multiplier.
// Zero and all-ones exponents are operand classes (no denormals); specials
// collapse to one all-ones encoding. A single stage enable advances the whole
// pipe, so a stalled result freezes every stage behind it.
module dlfloat_mul_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9,
  parameter int ID_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   rnd_mode,
  input  logic [ID_W-1:0]        in_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c_mul,
  output logic [ID_W-1:0]        out_id,
  output logic [4:0]             exception_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;       // wide enough that ea+eb-BIAS+2 never wraps
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [EXP_W-1:0]    EXP_MAX  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic signed [EW-1:0] BIAS_X  = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_OVF   = EW'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_SPEC, K_INV} kind_t;

  logic adv, accept;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;
  assign accept   = in_valid & in_ready;

  // operand classification and exponent sum feeding stage 1
  logic [EXP_W-1:0] ea, eb;
  logic a_zero, b_zero, a_spec, b_spec;
  kind_t kind_in;
  logic signed [EW-1:0] esum;

  assign ea     = a[W-2 -: EXP_W];
  assign eb     = b[W-2 -: EXP_W];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_spec = (ea == EXP_ONES);
  assign b_spec = (eb == EXP_ONES);
  assign esum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

  // priority order: invalid (special x zero), special, zero, normal
  always_comb begin
    kind_in = K_NORM;
    if ((a_spec && b_zero) || (a_zero && b_spec)) kind_in = K_INV;
    else if (a_spec || b_spec)                    kind_in = K_SPEC;
    else if (a_zero || b_zero)                    kind_in = K_ZERO;
  end

  logic                  v1, v2;
  kind_t                 k1, k2;
  logic                  sg1, sg2;
  logic signed [EW-1:0]  e1, e2;
  logic [SW-1:0]         ma1, mb1;
  logic [PW-1:0]         p2;
  logic                  r1, r2;
  logic [ID_W-1:0]       id1, id2;

  // stages 1 and 2: register classified operands, then the full product
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0; k1 <= K_NORM; sg1 <= 1'b0; e1 <= '0; ma1 <= '0; mb1 <= '0;
      r1 <= 1'b0; id1 <= '0;
      v2 <= 1'b0; k2 <= K_NORM; sg2 <= 1'b0; e2 <= '0; p2 <= '0;
      r2 <= 1'b0; id2 <= '0;
    end else if (adv) begin
      v1  <= accept;
      k1  <= kind_in;
      sg1 <= a[W-1] ^ b[W-1];
      e1  <= esum;
      ma1 <= {1'b1, a[MAN_W-1:0]};
      mb1 <= {1'b1, b[MAN_W-1:0]};
      r1  <= rnd_mode;
      id1 <= in_id;
      v2  <= v1;
      k2  <= k1;
      sg2 <= sg1;
      e2  <= e1;
      p2  <= ma1 * mb1;
      r2  <= r1;
      id2 <= id1;
    end
  end

  // normalise: product of two [1,2) significands lies in [1,4)
  logic [PW-2:0]        p_norm;
  logic signed [EW-1:0] e_n, e_r;
  logic [MAN_W-1:0]     man_t;
  logic                 guard, sticky, inc;
  logic [MAN_W:0]       man_r;
  logic                 ovf, unf;

  assign p_norm = p2[PW-1] ? p2[PW-2:0] : {p2[PW-3:0], 1'b0};
  assign e_n    = e2 + $signed({{(EW-1){1'b0}}, p2[PW-1]});
  assign man_t  = p_norm[PW-2 -: MAN_W];
  assign guard  = p_norm[PW-2-MAN_W];
  assign sticky = |p_norm[PW-3-MAN_W:0];
  assign inc    = r2 & guard & (sticky | man_t[0]);
  assign man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
  // a rounding carry leaves man_r[MAN_W-1:0] at zero, only the exponent moves
  assign e_r    = e_n + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
  assign ovf    = (e_r >= E_OVF);
  assign unf    = e_r[EW-1] | (e_r == '0);

  logic [W-1:0] res_c;
  logic [4:0]   res_f;

  // result selection and saturation; flags are {inv, inx, ovf, unf, dz}
  always_comb begin
    res_c = '0;
    res_f = 5'b00000;
    case (k2)
      K_INV: begin
        res_c = '1;
        res_f = 5'b10000;
      end
      K_SPEC: res_c = '1;
      K_ZERO: res_c = {sg2, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          res_c = {sg2, EXP_MAX, {MAN_W{1'b1}}};
          res_f = 5'b01100;
        end else if (unf) begin
          res_c = {sg2, {(W-1){1'b0}}};
          res_f = 5'b01010;
        end else begin
          res_c = {sg2, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
          res_f = {1'b0, guard | sticky, 3'b000};
        end
      end
    endcase
  end

  // stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      c_mul           <= '0;
      out_id          <= '0;
      exception_flags <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        c_mul           <= res_c;
        out_id          <= id2;
        exception_flags <= res_f;
      end
    end
  end

endmodule

// File: tb/tb_dlfloat_mul_pipe.sv
// tb_dlfloat_mul_pipe: directed vectors, randomized streams with backpressure
// and a mid-flight reset, checked against an integer reference model.
module tb_dlfloat_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        rnd_mode;
  logic [3:0]  in_id;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_mul;
  logic [3:0]  out_id;
  logic [4:0]  exception_flags;

  int total = 0;
  int bad   = 0;

  dlfloat_mul_pipe #(.EXP_W(6), .MAN_W(9), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .c_mul(c_mul),
    .out_id(out_id), .exception_flags(exception_flags)
  );

  always #5 clk = ~clk;

  localparam int ND = 10;
  localparam logic [15:0] DA [ND] = '{16'h3F00, 16'h4000, 16'h3F00, 16'h3F00, 16'h7DFF,
                                      16'hFDFF, 16'h0200, 16'hFFFF, 16'hFFFF, 16'h8000};
  localparam logic [15:0] DB [ND] = '{16'h3F00, 16'h4100, 16'h3E01, 16'h3E01, 16'h7DFF,
                                      16'h7DFF, 16'h0200, 16'h0000, 16'h3E00, 16'h3E00};
  localparam logic        DR [ND] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [15:0] DC [ND] = '{16'h4040, 16'h4300, 16'h3F02, 16'h3F01, 16'h7DFF,
                                      16'hFDFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000};
  localparam logic [4:0]  DF [ND] = '{5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b01100,
                                      5'b01100, 5'b01010, 5'b10000, 5'b00000, 5'b00000};

  // value-level model: exact integer product, then round by remainder vs half
  function automatic logic [20:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic rnd);
    int ex, ey, e, sh;
    longint p, m, rem, half;
    logic s, inx;
    ex = int'(x[14:9]);
    ey = int'(y[14:9]);
    s  = x[15] ^ y[15];
    if ((ex == 63 && ey == 0) || (ex == 0 && ey == 63)) return {5'b10000, 16'hFFFF};
    if (ex == 63 || ey == 63) return {5'b00000, 16'hFFFF};
    if (ex == 0 || ey == 0) return {5'b00000, s, 15'h0000};
    p = longint'(512 + int'(x[8:0])) * longint'(512 + int'(y[8:0]));
    e = ex + ey - 31;
    if (p >= longint'(524288)) begin
      e++;
      sh = 10;
    end else begin
      sh = 9;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
    if (rnd && (rem > half || (rem == half && m[0]))) m++;
    if (m == 1024) begin
      m = 512;
      e++;
    end
    if (e >= 63) return {5'b01100, s, 6'd62, 9'h1FF};
    if (e <= 0) return {5'b01010, s, 15'h0000};
    return {1'b0, inx, 3'b000, s, 6'(e), 9'(m - 512)};
  endfunction

  function automatic logic [15:0] rand_op();
    int sel;
    logic [5:0] e;
    logic [8:0] m;
    sel = $urandom_range(0, 15);
    m   = 9'($urandom);
    e   = 6'($urandom_range(18, 44));
    if (sel == 0) e = 6'h00;
    else if (sel == 1) e = 6'h3F;
    else if (sel <= 3) e = 6'($urandom);
    if (sel == 4) m = 9'h1FF;
    return {1'($urandom), e, m};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; rnd_mode = 1'b0; in_id = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++;
    if (c_mul !== 16'h0) begin bad++; $display("FAIL reset_c_mul got=%h exp=0000", c_mul); end
    total++;
    if (exception_flags !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", exception_flags); end
    total++;
    if (out_id !== 4'h0) begin bad++; $display("FAIL reset_id got=%h exp=0", out_id); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < ND; i++) begin
      a = DA[i]; b = DB[i]; rnd_mode = DR[i]; in_id = 4'(i);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      total++;
      if (lat != 3) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=3", i, lat); end
      total++;
      if (c_mul !== DC[i]) begin bad++; $display("FAIL dir%0d_c_mul got=%h exp=%h", i, c_mul, DC[i]); end
      total++;
      if (exception_flags !== DF[i]) begin
        bad++; $display("FAIL dir%0d_flags got=%b exp=%b", i, exception_flags, DF[i]);
      end
      total++;
      if (out_id !== 4'(i)) begin bad++; $display("FAIL dir%0d_id got=%h exp=%h", i, out_id, 4'(i)); end
      @(posedge clk);
      #1;
    end
  endtask

  // pv / pr: percent chance per cycle of offering an op / of out_ready
  task automatic test_stream(input string name, input int n_ops, input int pv, input int pr);
    logic [24:0] q[$];
    logic [24:0] e, prev_out;
    logic prev_stall;
    int sent, got, cyc, extra;
    sent = 0; got = 0; cyc = 0; extra = 0;
    prev_stall = 1'b0; prev_out = '0;
    while (got < n_ops && cyc < 40 * n_ops + 200) begin
      if (sent < n_ops && $urandom_range(0, 99) < pv) begin
        a = rand_op(); b = rand_op(); rnd_mode = 1'($urandom); in_id = 4'(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < pr);
      #1;
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || {out_id, exception_flags, c_mul} !== prev_out) begin
          bad++; $display("FAIL %s_hold got=%b/%h exp=1/%h", name, out_valid,
                          {out_id, exception_flags, c_mul}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL %s_extra got=%h exp=none", name, {out_id, exception_flags, c_mul});
        end else begin
          e = q.pop_front();
          got++;
          if ({out_id, exception_flags, c_mul} !== e) begin
            bad++; $display("FAIL %s_result got=%h exp=%h", name, {out_id, exception_flags, c_mul}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_id, ref_mul(a, b, rnd_mode)});
        sent++;
      end
      if (out_ready) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready); end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_id, exception_flags, c_mul};
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != n_ops) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, got, n_ops); end
    repeat (4) begin
      if (out_valid) extra++;
      @(posedge clk);
      #1;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL %s_drain got=%0d exp=0", name, extra); end
  endtask

  task automatic test_backpressure();
    logic [24:0] q[$];
    logic [24:0] e;
    int nxt, got, cyc;
    nxt = 0; got = 0; cyc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a = rand_op(); b = rand_op(); rnd_mode = 1'($urandom); in_id = 4'(nxt);
      in_valid = (nxt < 8);
      #1;
      if (in_valid && in_ready) begin
        q.push_back({in_id, ref_mul(a, b, rnd_mode)});
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (nxt != 3) begin bad++; $display("FAIL bp_accepts got=%0d exp=3", nxt); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    while (got < 8 && cyc < 300) begin
      if (nxt < 8) begin
        a = rand_op(); b = rand_op(); rnd_mode = 1'($urandom); in_id = 4'(nxt);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra got=%h exp=none", {out_id, exception_flags, c_mul});
        end else begin
          e = q.pop_front();
          if ({out_id, exception_flags, c_mul} !== e || out_id !== 4'(got)) begin
            bad++; $display("FAIL bp_result got=%h exp=%h", {out_id, exception_flags, c_mul}, e);
          end
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_id, ref_mul(a, b, rnd_mode)});
        nxt++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 8 || nxt != 8) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=8/8", got, nxt); end
  endtask

  task automatic test_mid_reset();
    int stale;
    stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand_op(); b = rand_op(); rnd_mode = 1'b1; in_id = 4'(9 + i);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
    total++;
    if (c_mul !== 16'h0) begin bad++; $display("FAIL mrst_c_mul got=%h exp=0000", c_mul); end
    total++;
    if (exception_flags !== 5'b0) begin bad++; $display("FAIL mrst_flags got=%b exp=00000", exception_flags); end
    total++;
    if (out_id !== 4'h0) begin bad++; $display("FAIL mrst_id got=%h exp=0", out_id); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
    repeat (8) begin
      if (out_valid) stale++;
      @(posedge clk);
      #1;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL mrst_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream("back_to_back", 64, 100, 100);
    test_stream("random", 300, 70, 60);
    test_backpressure();
    test_mid_reset();
    test_stream("post_reset", 50, 80, 80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
